// File: rtl/mc_mb_sequencer.sv
`timescale 1ns/1ps
// mc_mb_sequencer
// Macroblock sequencer for the motion-compensation path. A 0->1 transition of
// MV_fin in idle starts a frame: the frame is walked in raster order, one MC
// request per colour channel per MB, followed by one loop-filter hand-off per
// MB tagged with that MB's concealment flag. All hand-offs use valid/ready.
//
// Ports
//   CLK          clock, all logic on the rising edge
//   reset        synchronous, active-low
//   height/width frame size in MBs, latched at start
//   MV_fin       motion vectors ready; rising transition starts a frame
//   conceal_all  conceal the whole frame, latched at start
//   mv_err       MV missing for the current MB, sampled on the ch0 MC accept
//   mc_valid/mc_ready, mc_x, mc_y, mc_ch, mc_conceal   MC request channel
//   lf_valid/lf_ready, LF_conceal                       loop-filter hand-off
//   busy         frame in progress
//   frame_done   one-cycle pulse once the last MB is accepted by the loop filter
module mc_mb_sequencer #(
    parameter int DIM_W  = 8,
    parameter int NUM_CH = 3,
    parameter int CH_W   = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [DIM_W-1:0] height,
    input  logic [DIM_W-1:0] width,
    input  logic             MV_fin,
    input  logic             conceal_all,
    input  logic             mv_err,
    output logic             mc_valid,
    input  logic             mc_ready,
    output logic [DIM_W-1:0] mc_x,
    output logic [DIM_W-1:0] mc_y,
    output logic [CH_W-1:0]  mc_ch,
    output logic             mc_conceal,
    output logic             lf_valid,
    input  logic             lf_ready,
    output logic             LF_conceal,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MC   = 2'd1;
    localparam logic [1:0] S_LF   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [DIM_W-1:0] h_reg, h_next;
    logic [DIM_W-1:0] w_reg, w_next;
    logic [DIM_W-1:0] x_reg, x_next;
    logic [DIM_W-1:0] y_reg, y_next;
    logic [CH_W-1:0]  ch_reg, ch_next;
    logic             conceal_all_reg, conceal_all_next;
    logic             mb_conc_reg, mb_conc_next;
    logic             mv_fin_prev_reg;
    // Set once MV_fin has been seen low since reset. The edge register is
    // cleared by reset, so without this a level held high across reset would
    // look like a fresh 0->1 transition and restart the frame.
    logic             armed_reg;

    logic start;
    logic last_ch;
    logic last_x;
    logic last_y;
    logic ch0_conc;

    assign start    = (state_reg == S_IDLE) && MV_fin && !mv_fin_prev_reg && armed_reg;
    assign last_ch  = (ch_reg == CH_W'(NUM_CH - 1));
    assign last_x   = (x_reg == w_reg - DIM_W'(1));
    assign last_y   = (y_reg == h_reg - DIM_W'(1));
    // Channel 0 reports concealment before mb_conc_reg has captured it.
    assign ch0_conc = conceal_all_reg | mv_err;

    always_comb begin
        state_next       = state_reg;
        h_next           = h_reg;
        w_next           = w_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        ch_next          = ch_reg;
        conceal_all_next = conceal_all_reg;
        mb_conc_next     = mb_conc_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    h_next           = height;
                    w_next           = width;
                    conceal_all_next = conceal_all;
                    x_next           = '0;
                    y_next           = '0;
                    ch_next          = '0;
                    mb_conc_next     = 1'b0;
                    state_next       = (height == '0 || width == '0) ? S_DONE : S_MC;
                end
            end
            S_MC: begin
                if (mc_ready) begin
                    if (ch_reg == '0) begin
                        mb_conc_next = ch0_conc;
                    end
                    if (last_ch) begin
                        ch_next    = '0;
                        state_next = S_LF;
                    end else begin
                        ch_next = ch_reg + CH_W'(1);
                    end
                end
            end
            S_LF: begin
                if (lf_ready) begin
                    if (!last_x) begin
                        x_next     = x_reg + DIM_W'(1);
                        state_next = S_MC;
                    end else begin
                        x_next = '0;
                        if (!last_y) begin
                            y_next     = y_reg + DIM_W'(1);
                            state_next = S_MC;
                        end else begin
                            state_next = S_DONE;
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            h_reg           <= '0;
            w_reg           <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            ch_reg          <= '0;
            conceal_all_reg <= 1'b0;
            mb_conc_reg     <= 1'b0;
            mv_fin_prev_reg <= 1'b0;
            armed_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            h_reg           <= h_next;
            w_reg           <= w_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            ch_reg          <= ch_next;
            conceal_all_reg <= conceal_all_next;
            mb_conc_reg     <= mb_conc_next;
            mv_fin_prev_reg <= MV_fin;
            armed_reg       <= armed_reg | !MV_fin;
        end
    end

    assign mc_valid   = (state_reg == S_MC);
    assign lf_valid   = (state_reg == S_LF);
    assign busy       = mc_valid | lf_valid;
    assign frame_done = (state_reg == S_DONE);
    assign mc_x       = x_reg;
    assign mc_y       = y_reg;
    assign mc_ch      = ch_reg;
    assign mc_conceal = mc_valid && ((ch_reg == '0) ? ch0_conc : mb_conc_reg);
    assign LF_conceal = lf_valid && mb_conc_reg;

endmodule

// File: tb/tb_mc_mb_sequencer.sv
`timescale 1ns/1ps
// Bench for mc_mb_sequencer. A queue model lists every MC request and LF
// hand-off a frame must produce (raster order, per-MB concealment); the
// per-cycle monitor pops it on each accepted handshake and also checks
// stability under stall, mutual exclusion of the valids and frame_done.
module tb_mc_mb_sequencer;
    localparam int DIM_W  = 8;
    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;

    logic             CLK = 1'b0;
    logic             reset = 1'b0;
    logic [DIM_W-1:0] height = '0;
    logic [DIM_W-1:0] width = '0;
    logic             MV_fin = 1'b0;
    logic             conceal_all = 1'b0;
    logic             mv_err = 1'b0;
    logic             mc_ready = 1'b1;
    logic             lf_ready = 1'b1;
    logic             mc_valid, mc_conceal, lf_valid, LF_conceal, busy, frame_done;
    logic [DIM_W-1:0] mc_x, mc_y;
    logic [CH_W-1:0]  mc_ch;

    always #5 CLK = ~CLK;

    mc_mb_sequencer #(.DIM_W(DIM_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .CLK(CLK), .reset(reset), .height(height), .width(width), .MV_fin(MV_fin),
        .conceal_all(conceal_all), .mv_err(mv_err), .mc_valid(mc_valid), .mc_ready(mc_ready),
        .mc_x(mc_x), .mc_y(mc_y), .mc_ch(mc_ch), .mc_conceal(mc_conceal),
        .lf_valid(lf_valid), .lf_ready(lf_ready), .LF_conceal(LF_conceal),
        .busy(busy), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] ch;
        logic       conc;
    } mc_exp_t;

    mc_exp_t mc_q[$];
    logic    lf_q[$];

    int chk_cnt = 0;
    int pass_cnt = 0;
    int n_mc = 0, n_lf = 0, n_mc_conc = 0, n_lf_conc = 0, n_done = 0, n_mc_valid = 0;
    int max_x = 0;
    bit stall_en = 1'b0;
    bit err_en = 1'b0;
    int err_x = 0, err_y = 0;
    bit mc_hold = 1'b0, lf_hold = 1'b0;
    logic [18:0] mc_held = '0;
    logic        lf_held = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    endtask

    task automatic update_mv_err();
        mv_err = (mc_q.size() > 0) && err_en &&
                 (mc_q[0].x == 8'(err_x)) && (mc_q[0].y == 8'(err_y));
    endtask

    // Sample outputs at the falling edge (handshakes seen here complete at the
    // next rising edge), then drive the ready lines just after the rising edge.
    task automatic monitor();
        mc_exp_t e;
        logic    l;
        if (!reset) begin
            mc_q.delete();
            lf_q.delete();
            mc_hold = 1'b0;
            lf_hold = 1'b0;
            mv_err  = 1'b0;
            return;
        end
        chk("valid_excl", 32'(mc_valid & lf_valid), 0);
        if (mc_valid) n_mc_valid++;
        if (mc_hold) begin
            chk("mc_stall_valid", 32'(mc_valid), 1);
            chk("mc_stall_fields", 32'({mc_x, mc_y, mc_ch, mc_conceal}), 32'(mc_held));
        end
        if (lf_hold) begin
            chk("lf_stall_valid", 32'(lf_valid), 1);
            chk("lf_stall_conceal", 32'(LF_conceal), 32'(lf_held));
        end
        if (mc_valid && mc_ready) begin
            chk("mc_expected", 32'(mc_q.size() > 0), 1);
            if (mc_q.size() > 0) begin
                e = mc_q.pop_front();
                chk("mc_x", 32'(mc_x), 32'(e.x));
                chk("mc_y", 32'(mc_y), 32'(e.y));
                chk("mc_ch", 32'(mc_ch), 32'(e.ch));
                chk("mc_conceal", 32'(mc_conceal), 32'(e.conc));
            end
            $display("mc  x=%0d y=%0d ch=%0d conceal=%0d", mc_x, mc_y, mc_ch, mc_conceal);
            n_mc++;
            if (mc_conceal) n_mc_conc++;
            if (int'(mc_x) > max_x) max_x = int'(mc_x);
        end
        if (lf_valid && lf_ready) begin
            chk("lf_expected", 32'(lf_q.size() > 0), 1);
            if (lf_q.size() > 0) begin
                l = lf_q.pop_front();
                chk("lf_conceal", 32'(LF_conceal), 32'(l));
                chk("lf_mc_done_first", 32'(lf_q.size() * NUM_CH), 32'(mc_q.size()));
            end
            $display("lf  x=%0d y=%0d conceal=%0d", mc_x, mc_y, LF_conceal);
            n_lf++;
            if (LF_conceal) n_lf_conc++;
        end
        mc_hold = mc_valid && !mc_ready;
        mc_held = {mc_x, mc_y, mc_ch, mc_conceal};
        lf_hold = lf_valid && !lf_ready;
        lf_held = LF_conceal;
        if (frame_done) begin
            n_done++;
            $display("frame_done");
            chk("done_mc_drained", 32'(mc_q.size()), 0);
            chk("done_lf_drained", 32'(lf_q.size()), 0);
            chk("done_busy_low", 32'(busy), 0);
        end
        update_mv_err();
    endtask

    task automatic step();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
        if (stall_en) begin
            mc_ready = 1'($urandom_range(0, 1));
            lf_ready = 1'($urandom_range(0, 1));
        end else begin
            mc_ready = 1'b1;
            lf_ready = 1'b1;
        end
    endtask

    // Load the model with every transaction of the frame and raise MV_fin.
    task automatic start_frame(input int h, input int w, input bit ca,
                               input bit een, input int ex, input int ey);
        err_en = een;
        err_x  = ex;
        err_y  = ey;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                logic c;
                c = ca || (een && xx == ex && yy == ey);
                for (int cc = 0; cc < NUM_CH; cc++)
                    mc_q.push_back({8'(xx), 8'(yy), 2'(cc), c});
                lf_q.push_back(c);
            end
        end
        height      = DIM_W'(h);
        width       = DIM_W'(w);
        conceal_all = ca;
        update_mv_err();
        MV_fin      = 1'b1;
    endtask

    task automatic run_frame(input string tag, input int h, input int w, input bit ca,
                             input bit een, input int ex, input int ey, input int exp_cycles,
                             input int exp_mc, input int exp_lf, input int exp_mcc, input int exp_lfc);
        int b_mc, b_lf, b_mcc, b_lfc, b_done, b_val, n;
        b_mc = n_mc; b_lf = n_lf; b_mcc = n_mc_conc; b_lfc = n_lf_conc;
        b_done = n_done; b_val = n_mc_valid;
        start_frame(h, w, ca, een, ex, ey);
        chk({tag, "_idle_before_start"}, 32'(mc_valid), 0);
        step();
        n = 1;
        // Latched dimensions must ignore later changes on the inputs.
        height = 8'd7;
        width  = 8'd9;
        if (h > 0 && w > 0) begin
            chk({tag, "_first_valid"}, 32'(mc_valid), 1);
            chk({tag, "_first_xych"}, 32'({mc_x, mc_y, mc_ch}), 0);
            chk({tag, "_busy"}, 32'(busy), 1);
        end
        while (!frame_done && n < 5000) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(frame_done), 1);
        if (exp_cycles >= 0) chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        MV_fin = 1'b0;
        step();
        step();
        chk({tag, "_mc_count"}, 32'(n_mc - b_mc), 32'(exp_mc));
        chk({tag, "_lf_count"}, 32'(n_lf - b_lf), 32'(exp_lf));
        chk({tag, "_mc_conc_count"}, 32'(n_mc_conc - b_mcc), 32'(exp_mcc));
        chk({tag, "_lf_conc_count"}, 32'(n_lf_conc - b_lfc), 32'(exp_lfc));
        chk({tag, "_done_once"}, 32'(n_done - b_done), 1);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        if (exp_mc == 0) chk({tag, "_no_mc_valid"}, 32'(n_mc_valid - b_val), 0);
    endtask

    initial begin
        int n, b_done;
        reset = 1'b0;
        repeat (3) step();
        chk("rst_outputs", 32'({mc_valid, lf_valid, busy, frame_done, mc_conceal, LF_conceal}), 0);
        chk("rst_coords", 32'({mc_x, mc_y, mc_ch}), 0);
        reset = 1'b1;
        step();
        step();

        // T1: 2x2, readys high: 12 MC, 4 LF, done 16 cycles after first mc_valid
        run_frame("t1", 2, 2, 1'b0, 1'b0, 0, 0, 17, 12, 4, 0, 0);
        // T2: mv_err only on MB (1,0)
        run_frame("t2", 2, 2, 1'b0, 1'b1, 1, 0, 17, 12, 4, 3, 1);
        // T3: random stalls on both ready lines
        stall_en = 1'b1;
        run_frame("t3", 2, 2, 1'b0, 1'b1, 0, 1, -1, 12, 4, 3, 1);
        stall_en = 1'b0;
        step();
        // T4: zero height: frame_done the cycle after start, no transactions
        run_frame("t4", 0, 5, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0, 0);

        // T5: reset during MB (1,1) ch1, MV_fin held high afterwards
        start_frame(2, 2, 1'b0, 1'b0, 0, 0);
        n = 0;
        while (!(mc_valid && mc_x == 8'd1 && mc_y == 8'd1 && mc_ch == 2'd1) && n < 50) begin
            step();
            n++;
        end
        chk("t5_reached_mb11_ch1", 32'(n < 50), 1);
        b_done = n_done;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t5_outputs_cleared", 32'({mc_valid, lf_valid, busy, frame_done, mc_conceal, LF_conceal}), 0);
        chk("t5_coords_cleared", 32'({mc_x, mc_y, mc_ch}), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_no_restart", 32'({mc_valid, busy}), 0);
        end
        chk("t5_no_frame_done", 32'(n_done - b_done), 0);
        MV_fin = 1'b0;
        step();
        run_frame("t5r", 2, 2, 1'b0, 1'b0, 0, 0, 17, 12, 4, 0, 0);

        // T6: one row of 255 MBs, all concealed
        run_frame("t6", 1, 255, 1'b1, 1'b0, 0, 0, 1021, 765, 255, 765, 255);
        b_done = n_done;
        repeat (4) step();
        chk("t6_single_done", 32'(n_done - b_done), 0);
        chk("t6_max_x", 32'(max_x), 254);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
